tile_writer: RTL and testbench

TILE_WRITER -- requirements
Module: tile_writer

---
 rtl/tile_writer.sv | 201 ++++++++++++++++++++
 tb/tb_tile_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_writer.sv
// tile_writer: packs a stream of DATA_WIDTH elements into TILE_WIDTH tiles
// and writes one full destination buffer per job, zero-padding after in_last.
// Optional macro TILE_WRITER_ACK_CHECK_EN: check the writing_done completion pulse.
module tile_writer #(
    parameter int BUFFER_WIDTH = 1024,
    parameter int BUFFER_COUNT = 2,
    parameter int TILE_WIDTH   = 256,
    parameter int DATA_WIDTH   = 8,
    parameter int TILE_SIZE    = 32,
    localparam int BW = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
    localparam int CW = $clog2(BUFFER_WIDTH / DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BW-1:0]         dest_buffer,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  write_enable,
    output logic [TILE_WIDTH-1:0] write_data,
    output logic [BW-1:0]         write_buffer,
    input  logic                  writing_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CW-1:0]         byte_count
);

    localparam int TILE_COUNT = BUFFER_WIDTH / TILE_WIDTH;
    localparam int EW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int TW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
    localparam logic [EW-1:0] LAST_ELEM = EW'(TILE_SIZE - 1);
    localparam logic [TW-1:0] LAST_TILE = TW'(TILE_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        PAD,
        FINISH
    } state_t;

    state_t                state_q;
    logic [EW-1:0]         elem_q;
    logic [TW-1:0]         tile_q;
    logic                  last_seen_q;
    logic                  ack_wait_q;
    logic                  in_ready_q;
    logic                  write_enable_q;
    logic [TILE_WIDTH-1:0] write_data_q;
    logic [BW-1:0]         write_buffer_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [CW-1:0]         byte_count_q;

    logic                  accept;
    logic [TILE_WIDTH-1:0] tile_d;
    logic                  stray_ack;

    assign accept = in_valid && in_ready_q;

    // Current tile with the incoming element merged into its slot.
    always_comb begin
        tile_d = write_data_q;
        tile_d[int'(elem_q) * DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

`ifdef TILE_WRITER_ACK_CHECK_EN
    assign stray_ack = writing_done && !(state_q == FINISH && ack_wait_q);
`else
    logic unused_writing_done;
    assign unused_writing_done = writing_done;
    assign stray_ack = 1'b0;
`endif

    // Job sequencer: fill tiles, write them, pad the tail, report completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            elem_q         <= '0;
            tile_q         <= '0;
            last_seen_q    <= 1'b0;
            ack_wait_q     <= 1'b0;
            in_ready_q     <= 1'b0;
            write_enable_q <= 1'b0;
            write_data_q   <= '0;
            write_buffer_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            byte_count_q   <= '0;
        end else begin
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
            if (stray_ack) begin
                error_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        write_buffer_q <= dest_buffer;
                        elem_q         <= '0;
                        tile_q         <= '0;
                        last_seen_q    <= 1'b0;
                        ack_wait_q     <= 1'b0;
                        byte_count_q   <= '0;
                        error_q        <= 1'b0;
                        write_data_q   <= '0;
                        busy_q         <= 1'b1;
                        in_ready_q     <= 1'b1;
                        state_q        <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        write_data_q <= tile_d;
                        byte_count_q <= byte_count_q + 1'b1;
                        elem_q       <= elem_q + 1'b1;
                        if (in_last) begin
                            last_seen_q <= 1'b1;
                        end
                        if (in_last || elem_q == LAST_ELEM) begin
                            in_ready_q     <= 1'b0;
                            write_enable_q <= 1'b1;
                            state_q        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (tile_q == LAST_TILE) begin
                        state_q <= FINISH;
`ifdef TILE_WRITER_ACK_CHECK_EN
                        ack_wait_q <= 1'b1;
`else
                        done_q <= 1'b1;
`endif
                    end else begin
                        tile_q       <= tile_q + 1'b1;
                        elem_q       <= '0;
                        write_data_q <= '0;
                        if (last_seen_q) begin
                            write_enable_q <= 1'b1;
                            state_q        <= PAD;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= FILL;
                        end
                    end
                end
                PAD: begin
                    if (tile_q == LAST_TILE) begin
                        state_q <= FINISH;
`ifdef TILE_WRITER_ACK_CHECK_EN
                        ack_wait_q <= 1'b1;
`else
                        done_q <= 1'b1;
`endif
                    end else begin
                        tile_q         <= tile_q + 1'b1;
                        write_enable_q <= 1'b1;
                    end
                end
                FINISH: begin
`ifdef TILE_WRITER_ACK_CHECK_EN
                    if (ack_wait_q) begin
                        ack_wait_q <= 1'b0;
                        done_q     <= 1'b1;
                        if (!writing_done) begin
                            error_q <= 1'b1;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign write_enable = write_enable_q;
    assign write_data   = write_data_q;
    assign write_buffer = write_buffer_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: randomized jobs against a buffer-image reference model
// for tile_writer (default parameters: 4 tiles of 32 bytes).
module tb_tile_writer;

    localparam int TILE_COUNT = 4;
    localparam int TILE_SIZE  = 32;
    localparam int NBYTES     = TILE_COUNT * TILE_SIZE;
`ifdef TILE_WRITER_ACK_CHECK_EN
    localparam int DONE_LAT = 2;
`else
    localparam int DONE_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [0:0]   dest_buffer;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         write_enable;
    logic [255:0] write_data;
    logic [0:0]   write_buffer;
    logic         writing_done;
    logic         busy;
    logic         done;
    logic         error;
    logic [7:0]   byte_count;

    always #5 clk = ~clk;

    tile_writer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dest_buffer  (dest_buffer),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_buffer (write_buffer),
        .writing_done (writing_done),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .byte_count   (byte_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observer: transfers, tile writes and done pulses, sampled mid-cycle.
    int           cyc = 0;
    int           acc_cnt = 0;
    int           done_cnt = 0;
    int           rdy_in_write = 0;
    int           last_we_cyc = 0;
    int           done_cyc = 0;
    logic [255:0] wr_data_q[$];
    logic [0:0]   wr_buf_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (in_valid && in_ready) acc_cnt++;
            if (write_enable) begin
                wr_data_q.push_back(write_data);
                wr_buf_q.push_back(write_buffer);
                last_we_cyc = cyc;
                if (in_ready) rdy_in_write++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    logic [7:0] data_mem[NBYTES];

    task automatic clear_obs();
        acc_cnt = 0;
        done_cnt = 0;
        rdy_in_write = 0;
        wr_data_q.delete();
        wr_buf_q.delete();
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_in_ready"}, 256'(in_ready), 256'(0));
        check_eq({pfx, "_we"}, 256'(write_enable), 256'(0));
        check_eq({pfx, "_wdata"}, write_data, 256'(0));
        check_eq({pfx, "_wbuf"}, 256'(write_buffer), 256'(0));
        check_eq({pfx, "_busy"}, 256'(busy), 256'(0));
        check_eq({pfx, "_done"}, 256'(done), 256'(0));
        check_eq({pfx, "_error"}, 256'(error), 256'(0));
        check_eq({pfx, "_bcount"}, 256'(byte_count), 256'(0));
    endtask

    // One job: start, stream n bytes with random gaps, compare the buffer image.
    task automatic run_job(input logic [0:0] dest, input int n,
                           input bit with_last, input bit glitch, input bit ack);
        bit           glitched = 0;
        bit           ack_sent = 0;
        bit           exp_err;
        int           idx;
        logic [255:0] exp_tile;
`ifdef TILE_WRITER_ACK_CHECK_EN
        exp_err = !ack;
`else
        exp_err = 1'b0;
`endif
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1;
        dest_buffer = dest;
        in_valid = 1'b1;
        in_data = 8'hEE;
        in_last = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            if (acc_cnt < n) begin
                in_valid = ($urandom_range(3) != 0);
                in_data = data_mem[acc_cnt];
                in_last = with_last && (acc_cnt == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
            if (glitch && !glitched && acc_cnt >= 10) begin
                start = 1'b1;
                dest_buffer = ~dest;
                glitched = 1'b1;
            end else begin
                start = 1'b0;
            end
            writing_done = ack && !ack_sent && (wr_data_q.size() == TILE_COUNT);
            if (writing_done) ack_sent = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        writing_done = 1'b0;
        if (done_cnt == 0) check_eq("done_timeout", 256'(0), 256'(1));
        repeat (3) @(posedge clk);
        #1;
        check_eq("n_writes", 256'(wr_data_q.size()), 256'(TILE_COUNT));
        for (int t = 0; t < TILE_COUNT; t++) begin
            exp_tile = '0;
            for (int k = 0; k < TILE_SIZE; k++) begin
                idx = t * TILE_SIZE + k;
                if (idx < n) exp_tile[k*8 +: 8] = data_mem[idx];
            end
            if (t < wr_data_q.size()) begin
                check_eq($sformatf("tile%0d_data", t), wr_data_q[t], exp_tile);
                check_eq($sformatf("tile%0d_buf", t), 256'(wr_buf_q[t]), 256'(dest));
            end
        end
        check_eq("accepted", 256'(acc_cnt), 256'(n));
        check_eq("byte_count", 256'(byte_count), 256'(n));
        check_eq("done_pulses", 256'(done_cnt), 256'(1));
        check_eq("done_latency", 256'(done_cyc - last_we_cyc), 256'(DONE_LAT));
        check_eq("busy_after", 256'(busy), 256'(0));
        check_eq("error", 256'(error), 256'(exp_err));
        check_eq("ready_in_write", 256'(rdy_in_write), 256'(0));
    endtask

    // Abandon a job by reset after 50 bytes; nothing more may be written.
    task automatic run_reset_job();
        int nw;
        clear_obs();
        for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b1;
        dest_buffer = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 1000 && acc_cnt < 50; c++) begin
            in_valid = ($urandom_range(3) != 0);
            in_data = data_mem[acc_cnt];
            in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("rst_accepted", 256'(acc_cnt), 256'(50));
        check_eq("rst_pre_writes", 256'(wr_data_q.size()), 256'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midjob");
        nw = wr_data_q.size();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_no_writes", 256'(wr_data_q.size()), 256'(nw));
    endtask

    initial begin
        int  n;
        bit  lst;
        reset = 1'b1;
        start = 1'b0;
        dest_buffer = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        writing_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'(i);
        run_job(1'b1, NBYTES, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'($urandom);
        run_job(1'b0, 40, 1'b1, 1'b0, 1'b1);
        run_job(1'b1, NBYTES, 1'b1, 1'b0, 1'b1);
        run_job(1'b0, 32, 1'b1, 1'b0, 1'b1);
        run_job(1'b0, 1, 1'b1, 1'b0, 1'b1);
        run_job(1'b0, 70, 1'b1, 1'b1, 1'b1);
        run_job(1'b1, NBYTES, 1'b0, 1'b1, 1'b1);

        run_reset_job();
        for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'($urandom);
        run_job(1'b0, NBYTES, 1'b0, 1'b0, 1'b1);

        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < NBYTES; i++) data_mem[i] = 8'($urandom);
            n = $urandom_range(1, NBYTES);
            lst = (n < NBYTES) ? 1'b1 : 1'($urandom_range(1));
`ifdef TILE_WRITER_ACK_CHECK_EN
            run_job(1'($urandom_range(1)), n, lst, n > 12, 1'b1);
`else
            run_job(1'($urandom_range(1)), n, lst, n > 12, 1'($urandom_range(1)));
`endif
        end

`ifdef TILE_WRITER_ACK_CHECK_EN
        run_job(1'b1, 50, 1'b1, 1'b0, 1'b0);
        run_job(1'b0, 90, 1'b1, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
